// File: rtl/ip_sequencer.sv
// Instruction-pointer sequencer: advance/branch/jump plus a bounded call/return stack.
// Every command resolves in one clk edge; stack misuse is dropped and latched in sticky flags.
module ip_sequencer #(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               advance,
  input  logic [2:0]                         adv_len,
  input  logic                               jump,
  input  logic                               branch,
  input  logic                               call,
  input  logic                               ret,
  input  logic [ADDR_W-1:0]                  target,
  input  logic [ADDR_W-1:0]                  disp,
  output logic [ADDR_W-1:0]                  ip,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int unsigned          DEPTH_W    = $clog2(STACK_DEPTH + 1);
  localparam int unsigned          PTR_W      = $clog2(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0]   FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

  logic [ADDR_W-1:0]  ip_q, ip_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0]  next_ip;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;

  assign next_ip = ip_q + ADDR_W'(adv_len);
  // depth never exceeds STACK_DEPTH, so its low bits address the free slot
  // whenever a push is legal, and one below that is the top of stack.
  assign wr_ptr  = depth_q[PTR_W-1:0];
  assign rd_ptr  = wr_ptr - PTR_W'(1);

  always_comb begin
    ip_d        = ip_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push        = 1'b0;
    if (ret) begin
      if (depth_q != '0) begin
        ip_d    = stack_q[rd_ptr];
        depth_d = depth_q - DEPTH_W'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end else if (call) begin
      if (depth_q != FULL_DEPTH) begin
        push    = 1'b1;
        ip_d    = target;
        depth_d = depth_q + DEPTH_W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end else if (jump) begin
      ip_d = target;
    end else if (branch) begin
      ip_d = next_ip + disp;
    end else if (advance) begin
      ip_d = next_ip;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ip_q        <= RESET_VECTOR;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ip_q        <= ip_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is left unreset; entries at or above depth are never read.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack_q[wr_ptr] <= next_ip;
    end
  end

  assign ip          = ip_q;
  assign depth       = depth_q;
  assign stack_full  = (depth_q == FULL_DEPTH);
  assign stack_empty = (depth_q == '0);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_ip_sequencer.sv
// Randomized + directed bench for ip_sequencer with a queue-based reference model and scoreboard.
module tb_ip_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        advance = 1'b0;
  logic [2:0]  adv_len = '0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [15:0] target = '0;
  logic [15:0] disp = '0;
  logic [15:0] ip;
  logic [3:0]  depth;
  logic        stack_full, stack_empty, overflow, underflow;

  ip_sequencer #(.ADDR_W(16), .STACK_DEPTH(DEPTH), .RESET_VECTOR(16'h0000)) dut (
    .clk(clk), .reset(reset), .advance(advance), .adv_len(adv_len),
    .jump(jump), .branch(branch), .call(call), .ret(ret),
    .target(target), .disp(disp), .ip(ip), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ip;
    int          depth;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_stack[$];
  logic [15:0] m_ip = 16'h0000;
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  int          vectors = 0;
  int          checks = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (vector %0d)", name, act, exp_v, vectors);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model by one edge.
  task automatic apply(input bit rst, input bit adv, input int len, input bit jmp,
                       input bit br, input bit cl, input bit rt,
                       input logic [15:0] tgt, input logic [15:0] dsp);
    logic [15:0] nxt;
    exp_t e;
    @(negedge clk);
    reset = rst; advance = adv; adv_len = 3'(len); jump = jmp; branch = br;
    call = cl; ret = rt; target = tgt; disp = dsp;
    nxt = m_ip + 16'(len);
    if (rst) begin
      m_ip = 16'h0000; m_stack.delete(); m_ovf = 0; m_unf = 0;
    end else if (rt) begin
      if (m_stack.size() > 0) m_ip = m_stack.pop_back();
      else m_unf = 1;
    end else if (cl) begin
      if (m_stack.size() < DEPTH) begin m_stack.push_back(nxt); m_ip = tgt; end
      else m_ovf = 1;
    end else if (jmp) m_ip = tgt;
    else if (br) m_ip = nxt + dsp;
    else if (adv) m_ip = nxt;
    e.ip = m_ip; e.depth = m_stack.size(); e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    vectors++;
  endtask

  task automatic idle();       apply(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0); endtask
  task automatic do_reset();   apply(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0); endtask
  task automatic do_adv(input int len); apply(0, 1, len, 0, 0, 0, 0, 16'h0, 16'h0); endtask
  task automatic do_call(input int len, input logic [15:0] t); apply(0, 0, len, 0, 0, 1, 0, t, 16'h0); endtask
  task automatic do_ret();     apply(0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0); endtask
  task automatic do_jump(input logic [15:0] t); apply(0, 0, 5, 1, 0, 0, 0, t, 16'h0); endtask

  // Monitor: every clock the DUT presents a new registered state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ip", int'(ip), int'(e.ip));
        chk("depth", int'(depth), e.depth);
        chk("stack_full", int'(stack_full), int'(e.depth == DEPTH));
        chk("stack_empty", int'(stack_empty), int'(e.depth == 0));
        chk("overflow", int'(overflow), int'(e.ovf));
        chk("underflow", int'(underflow), int'(e.unf));
      end
    end
  end

  initial begin
    int wait_cycles;
    do_reset();
    repeat (3) do_adv(3);
    apply(0, 1, 2, 0, 1, 0, 0, 16'h0, 16'hFFF0);
    do_adv(6);
    do_adv(0);
    idle();
    do_jump(16'h0100);
    do_call(3, 16'h2000);
    do_ret();
    for (int i = 0; i < 8; i++) do_call(i % 8, 16'(16'h1000 + i * 16'h0111));
    do_call(4, 16'hBEEF);
    for (int i = 0; i < 8; i++) do_ret();
    do_ret();
    idle();
    do_reset();
    do_call(2, 16'h3000);
    do_call(1, 16'h4000);
    apply(0, 1, 7, 1, 1, 1, 1, 16'h5555, 16'h0010);
    do_call(3, 16'h6000);
    do_call(3, 16'h7000);
    apply(1, 0, 4, 1, 0, 0, 0, 16'hABCD, 16'h0);
    do_ret();
    do_call(7, 16'hFFFE);
    apply(0, 1, 7, 0, 1, 0, 0, 16'h0, 16'h0003);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < 60), int'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 22), ($urandom_range(0, 99) < 18),
            16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    end
    idle();
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
